// File: rtl/program_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package program_loader_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler: four strobed bytes form one 32-bit word.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              strobe,
  input  logic              clear,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               byte_cnt;
  logic [WORD_W-BYTE_W-1:0] shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (strobe) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
    end
  end

  // The 4th byte completes the word combinationally so the top can register it.
  assign word_done = strobe && (byte_cnt == 2'd3);
  assign word      = {shift_q, byte_in};

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: writes big-endian words to instruction memory,
// then raises cpu_run. Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                imem_wren,
  output logic [31:0]         imem_addr,
  output logic [31:0]         imem_wdata,
  output logic [ADDR_WIDTH:0] words_loaded,
  output logic                cpu_run,
  output logic                load_error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = RUN;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_full;
  logic               xfer;
  logic               last_word;
  logic               word_done;
  logic [WORD_W-1:0]  word;

  assign xfer       = in_valid && in_ready;
  assign count_full = {count_q[CNT_W-1:BYTE_W], in_data};
  assign last_word  = (32'(words_loaded) + 32'd1) == 32'(count_q);

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (in_data),
    .strobe    (xfer && (state_q == DATA)),
    .clear     (state_q != DATA),
    .word_done (word_done),
    .word      (word)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (xfer && (state_q != CHECK)) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_HI: if (xfer) state_d = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (32'(count_full) > MAX_WORDS) state_d = ERROR;
          else if (count_full == '0)       state_d = END_STATE;
          else                             state_d = DATA;
        end
      end
      DATA: if (word_done && last_word) state_d = END_STATE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_d = (in_data == csum_q) ? RUN : ERROR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CNT_HI;
      count_q      <= '0;
      in_ready     <= 1'b0;
      imem_wren    <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      cpu_run      <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != RUN) && (state_d != ERROR);
      imem_wren <= word_done;
      if (xfer && (state_q == CNT_HI)) count_q[CNT_W-1:BYTE_W] <= in_data;
      if (xfer && (state_q == CNT_LO)) count_q[BYTE_W-1:0]     <= in_data;
      if (word_done) begin
        imem_addr  <= BASE_ADDR + 32'(words_loaded) * WORD_STRIDE;
        imem_wdata <= word;
        if (32'(words_loaded) < 32'(count_q))
          words_loaded <= words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      // After the final write, cpu_run waits one cycle behind the strobe;
      // other entries into RUN raise it on the transfer edge itself.
      cpu_run    <= cpu_run || (state_q == RUN) ||
                    ((state_d == RUN) && (state_q != DATA));
      load_error <= load_error || (state_d == ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default and BASE_ADDR=0x100 instances).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  in_data_a = '0, in_data_b = '0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic        imem_wren_a, imem_wren_b;
  logic [31:0] imem_addr_a, imem_addr_b, imem_wdata_a, imem_wdata_b;
  logic [8:0]  words_loaded_a, words_loaded_b;
  logic        cpu_run_a, cpu_run_b, load_error_a, load_error_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];

  always #5 clk = ~clk;

  program_loader dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .imem_wren(imem_wren_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .words_loaded(words_loaded_a),
    .cpu_run(cpu_run_a), .load_error(load_error_a)
  );

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .imem_wren(imem_wren_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .words_loaded(words_loaded_b),
    .cpu_run(cpu_run_b), .load_error(load_error_b)
  );

  always @(posedge clk) begin
    if (imem_wren_a) begin wa_addr.push_back(imem_addr_a); wa_data.push_back(imem_wdata_a); end
    if (imem_wren_b) begin wb_addr.push_back(imem_addr_b); wb_data.push_back(imem_wdata_b); end
  end

  task automatic send(input bit sel, input logic [7:0] b);
    int unsigned t = 0;
    @(negedge clk);
    if (sel) begin in_data_b = b; in_valid_b = 1'b1; end
    else     begin in_data_a = b; in_valid_a = 1'b1; end
    while (((sel ? in_ready_b : in_ready_a) !== 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if ((sel ? in_ready_b : in_ready_a) !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout byte %h got in_ready 0 exp 1", b);
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
  endtask

  task automatic test_reset();
    #12;
    vectors++; if ({in_ready_a, imem_wren_a, cpu_run_a, load_error_a} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {in_ready_a, imem_wren_a, cpu_run_a, load_error_a}); end
    vectors++; if ({imem_addr_a, imem_wdata_a} !== 64'h0) begin miscompares++; $display("FAIL reset_addr_data got %h exp 0", {imem_addr_a, imem_wdata_a}); end
    vectors++; if (words_loaded_a !== 9'd0) begin miscompares++; $display("FAIL reset_words got %0d exp 0", words_loaded_a); end
    @(negedge clk); rst = 1'b1; #1;
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL reset_ready_early got %b exp 0", in_ready_a); end
    @(posedge clk); #1;
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_ready_rise got %b exp 1", in_ready_a); end
  endtask

  task automatic test_basic(input bit idle);
    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    apply_reset();
    foreach (img[i]) begin
      send(1'b0, img[i]);
      if (i == 2) begin
        vectors++; if (imem_wren_a !== 1'b0) begin miscompares++; $display("FAIL basic_early_wren got %b exp 0", imem_wren_a); end
      end
      if (i == 5) begin
        vectors++; if ({imem_wren_a, imem_addr_a, imem_wdata_a} !== {1'b1, 32'h0, 32'h24080005}) begin miscompares++; $display("FAIL basic_w0 got %b %h %h exp 1 0 24080005", imem_wren_a, imem_addr_a, imem_wdata_a); end
        vectors++; if (words_loaded_a !== 9'd1) begin miscompares++; $display("FAIL basic_wl1 got %0d exp 1", words_loaded_a); end
      end
      if (i == 9) begin
        vectors++; if ({imem_wren_a, imem_addr_a, imem_wdata_a} !== {1'b1, 32'h4, 32'h8C090004}) begin miscompares++; $display("FAIL basic_w1 got %b %h %h exp 1 4 8c090004", imem_wren_a, imem_addr_a, imem_wdata_a); end
        vectors++; if (cpu_run_a !== 1'b0) begin miscompares++; $display("FAIL basic_run_early got %b exp 0", cpu_run_a); end
      end
      if (idle) begin
        @(posedge clk); #1;
        if (i == 5) begin
          vectors++; if (imem_wren_a !== 1'b0) begin miscompares++; $display("FAIL idle_wren_width got %b exp 0", imem_wren_a); end
        end
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(1'b0, 8'hAA);
`else
    if (!idle) begin @(posedge clk); #1; end
`endif
    vectors++; if ({cpu_run_a, load_error_a, in_ready_a, imem_wren_a} !== 4'b1000) begin miscompares++; $display("FAIL basic_done got run/err/rdy/wren %b exp 1000", {cpu_run_a, load_error_a, in_ready_a, imem_wren_a}); end
    vectors++; if (words_loaded_a !== 9'd2) begin miscompares++; $display("FAIL basic_wl2 got %0d exp 2", words_loaded_a); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (wa_addr.size() !== 2) begin miscompares++; $display("FAIL basic_nwrites got %0d exp 2", wa_addr.size()); end
    vectors++; if ({wa_addr[0], wa_data[0], wa_addr[1], wa_data[1]} !== {32'h0, 32'h24080005, 32'h4, 32'h8C090004}) begin miscompares++; $display("FAIL basic_log got %h %h %h %h", wa_addr[0], wa_data[0], wa_addr[1], wa_data[1]); end
  endtask

  task automatic test_oversize();
    apply_reset();
    send(1'b0, 8'h01);
    send(1'b0, 8'h01);
    vectors++; if ({load_error_a, in_ready_a, cpu_run_a} !== 3'b100) begin miscompares++; $display("FAIL over_flags got err/rdy/run %b exp 100", {load_error_a, in_ready_a, cpu_run_a}); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if ({load_error_a, cpu_run_a, imem_wren_a} !== 3'b100) begin miscompares++; $display("FAIL over_sticky got err/run/wren %b exp 100", {load_error_a, cpu_run_a, imem_wren_a}); end
    vectors++; if (wa_addr.size() !== 0) begin miscompares++; $display("FAIL over_nwrites got %0d exp 0", wa_addr.size()); end
  endtask

  task automatic test_zero();
    apply_reset();
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(1'b0, 8'h00);
`endif
    vectors++; if ({cpu_run_a, load_error_a, in_ready_a} !== 3'b100) begin miscompares++; $display("FAIL zero_done got run/err/rdy %b exp 100", {cpu_run_a, load_error_a, in_ready_a}); end
    vectors++; if (words_loaded_a !== 9'd0) begin miscompares++; $display("FAIL zero_wl got %0d exp 0", words_loaded_a); end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] img [6] = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    apply_reset();
    foreach (img[i]) send(1'b0, img[i]);
    vectors++; if (imem_wdata_a !== 32'h12345678) begin miscompares++; $display("FAIL csum_word got %h exp 12345678", imem_wdata_a); end
    send(1'b0, 8'h09);
    vectors++; if ({cpu_run_a, load_error_a} !== 2'b10) begin miscompares++; $display("FAIL csum_good got run/err %b exp 10", {cpu_run_a, load_error_a}); end
    apply_reset();
    foreach (img[i]) send(1'b0, img[i]);
    send(1'b0, 8'h08);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({cpu_run_a, load_error_a, in_ready_a} !== 3'b010) begin miscompares++; $display("FAIL csum_bad got run/err/rdy %b exp 010", {cpu_run_a, load_error_a, in_ready_a}); end
  endtask
`endif

  task automatic test_mid_reset();
    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    apply_reset();
    for (int i = 0; i < 8; i++) send(1'b0, img[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if ({in_ready_a, imem_wren_a, cpu_run_a, load_error_a, words_loaded_a} !== 13'd0) begin miscompares++; $display("FAIL mid_clear got rdy/wren/run/err/wl %b", {in_ready_a, imem_wren_a, cpu_run_a, load_error_a, words_loaded_a}); end
    vectors++; if ({imem_addr_a, imem_wdata_a} !== 64'h0) begin miscompares++; $display("FAIL mid_clear_bus got %h exp 0", {imem_addr_a, imem_wdata_a}); end
    vectors++; if (wa_addr.size() !== 1) begin miscompares++; $display("FAIL mid_prewrites got %0d exp 1", wa_addr.size()); end
    @(negedge clk);
    rst = 1'b1;
    wa_addr.delete(); wa_data.delete();
    foreach (img[i]) send(1'b0, img[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(1'b0, 8'hAA);
`endif
    repeat (3) @(posedge clk);
    #1;
    vectors++; if ({wa_addr.size() == 2, wa_addr[0], wa_addr[1]} !== {1'b1, 32'h0, 32'h4}) begin miscompares++; $display("FAIL mid_replay got n=%0d %h %h exp 2 0 4", wa_addr.size(), wa_addr[0], wa_addr[1]); end
    vectors++; if ({words_loaded_a, cpu_run_a} !== {9'd2, 1'b1}) begin miscompares++; $display("FAIL mid_done got wl %0d run %b exp 2 1", words_loaded_a, cpu_run_a); end
  endtask

  task automatic test_base();
    logic [7:0]  img [14] = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
                              8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  x = '0;
    logic        run_seen = 1'b0;
    apply_reset();
    foreach (img[i]) begin
      send(1'b1, img[i]);
      x = x ^ img[i];
      run_seen = run_seen | cpu_run_b;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(1'b1, x);
`else
    @(posedge clk); #1;
`endif
    vectors++; if (run_seen !== 1'b0) begin miscompares++; $display("FAIL base_run_during_load got 1 exp 0"); end
    vectors++; if ({cpu_run_b, words_loaded_b} !== {1'b1, 9'd3}) begin miscompares++; $display("FAIL base_done got run %b wl %0d exp 1 3", cpu_run_b, words_loaded_b); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({wb_addr.size() == 3, wb_addr[0], wb_addr[1], wb_addr[2]} !== {1'b1, 32'h100, 32'h104, 32'h108}) begin miscompares++; $display("FAIL base_addrs got n=%0d %h %h %h exp 100 104 108", wb_addr.size(), wb_addr[0], wb_addr[1], wb_addr[2]); end
    vectors++; if ({wb_data[0], wb_data[1], wb_data[2]} !== {32'h01020304, 32'hA0B0C0D0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL base_data got %h %h %h", wb_data[0], wb_data[1], wb_data[2]); end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_oversize();
    test_zero();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    test_base();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
